rx_param: RTL and testbench

Parametrised asynchronous serial receiver: next generation of the team's fixed 8-bit rx block.
- Converts LSB-first start/data/stop frames on rx_si into a parallel word.
- Presents the word to a downstream consumer with a ready/ack handshake.
- Adds over the current block: generic data width and bit period, 1 or 2 stop bits, start-glitch rejection, input synchroniser, overrun detection, and optional parity checking.

---
 rtl/rx_param.sv | 215 +++++++++++++++++++++
 tb/tb_rx_param.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_param.sv
// Parametrised asynchronous serial receiver (start/data/[parity]/stop, LSB first)
// with a ready/ack word handshake. Parity checking is compiled in by `define RX_PARITY_EN.
module rx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 8,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_si,
  input  logic              rx_data_ack,
  output logic [DATA_W-1:0] rx_po,
  output logic              rx_busy,
  output logic              rx_ready,
  output logic              rx_error,
  output logic              rx_overrun,
  output logic              rx_parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] MID_START = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] MID_BIT   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic             ODD_SENSE = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shreg;
  logic              frame_err;
  logic              frame_perr;
  logic              rx_s;
  logic              at_mid;
  logic              done;
  logic              done_ferr;

  // Synchroniser presets to idle-high so reset never looks like a start bit.
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_si};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    at_mid    = (state == S_START) ? (cnt == MID_START) : (cnt == MID_BIT);
    done      = (state == S_STOP) && at_mid && (idx == LAST_STOP);
    done_ferr = frame_err | ~rx_s;
  end

`ifdef RX_PARITY_EN
  logic par_acc;
`else
  assign frame_perr = 1'b0 & ODD_SENSE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
`ifdef RX_PARITY_EN
      par_acc    <= 1'b0;
      frame_perr <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          idx     <= '0;
          rx_busy <= 1'b0;
          if (!rx_s) begin
            state     <= S_START;
            rx_busy   <= 1'b1;
            frame_err <= 1'b0;
`ifdef RX_PARITY_EN
            par_acc    <= 1'b0;
            frame_perr <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (at_mid) begin
            cnt <= '0;
            idx <= '0;
            // A start bit that is high again at its centre was only a glitch.
            if (rx_s) begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (at_mid) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_W-1:1]};
`ifdef RX_PARITY_EN
            par_acc <= par_acc ^ rx_s;
`endif
            if (idx == LAST_DATA) begin
              idx <= '0;
`ifdef RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef RX_PARITY_EN
        S_PARITY: begin
          if (at_mid) begin
            cnt        <= '0;
            idx        <= '0;
            frame_perr <= par_acc ^ rx_s ^ ODD_SENSE;
            state      <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (at_mid) begin
            cnt <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
            end
            if (idx == LAST_STOP) begin
              idx <= '0;
              // A low last stop (break) must rise before a new start is accepted.
              state   <= rx_s ? S_IDLE : S_WAIT_HIGH;
              rx_busy <= ~rx_s;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          cnt     <= '0;
          idx     <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  // Handshake: rx_ready rises with a new word in rx_po and holds until an edge
  // with rx_data_ack=1, which consumes that word; ack with rx_ready=0 is ignored.
  // A word completing while the old one is unconsumed is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_po         <= '0;
      rx_ready      <= 1'b0;
      rx_error      <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_parity_err <= 1'b0;
    end else if (done) begin
      if (!rx_ready || rx_data_ack) begin
        rx_po         <= shreg;
        rx_ready      <= 1'b1;
        rx_error      <= done_ferr;
        rx_parity_err <= frame_perr;
        rx_overrun    <= 1'b0;
      end else begin
        rx_overrun <= 1'b1;
      end
    end else if (rx_data_ack && rx_ready) begin
      rx_ready      <= 1'b0;
      rx_error      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_param.sv
// Bench for rx_param: directed frames, a frame-level model compared every cycle,
// plus literal checks on key words and flags.
module tb_rx_param;

`ifdef RX_PARITY_EN
  localparam int DATA_W    = 7;
  localparam int STOP_BITS = 2;
  localparam int PAR_BITS  = 1;
`else
  localparam int DATA_W    = 8;
  localparam int STOP_BITS = 1;
  localparam int PAR_BITS  = 0;
`endif
  localparam int CPB        = 8;
  localparam int SYNC       = 2;
  localparam int PARITY_ODD = 0;
  localparam int LAT        = SYNC + CPB / 2 + (DATA_W + PAR_BITS + STOP_BITS) * CPB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_si = 1'b1;
  logic              rx_data_ack = 1'b0;
  logic [DATA_W-1:0] rx_po;
  logic              rx_busy;
  logic              rx_ready;
  logic              rx_error;
  logic              rx_overrun;
  logic              rx_parity_err;

  rx_param #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (STOP_BITS),
    .SYNC_STAGES (SYNC),
    .PARITY_ODD  (PARITY_ODD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_si        (rx_si),
    .rx_data_ack  (rx_data_ack),
    .rx_po        (rx_po),
    .rx_busy      (rx_busy),
    .rx_ready     (rx_ready),
    .rx_error     (rx_error),
    .rx_overrun   (rx_overrun),
    .rx_parity_err(rx_parity_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] word;
    logic              ferr;
    logic              perr;
  } done_t;

  done_t             exp_q[$];
  int                cyc = 0;
  int                last_done = 0;
  int                checks = 0;
  int                failures = 0;
  logic              cmp_en = 1'b0;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_po = '0;
  logic              m_err = 1'b0;
  logic              m_ovr = 1'b0;
  logic              m_perr = 1'b0;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Frame-level model: a frame lands LAT edges after its start is first seen.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready <= 1'b0;
      m_po    <= '0;
      m_err   <= 1'b0;
      m_ovr   <= 1'b0;
      m_perr  <= 1'b0;
      exp_q.delete();
    end else begin
      cyc <= cyc + 1;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc + 1) begin
        if (!m_ready || rx_data_ack) begin
          m_po    <= exp_q[0].word;
          m_ready <= 1'b1;
          m_err   <= exp_q[0].ferr;
          m_perr  <= exp_q[0].perr;
          m_ovr   <= 1'b0;
        end else begin
          m_ovr <= 1'b1;
        end
        void'(exp_q.pop_front());
      end else if (rx_data_ack && m_ready) begin
        m_ready <= 1'b0;
        m_err   <= 1'b0;
        m_perr  <= 1'b0;
        m_ovr   <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("cyc_ready", {15'd0, rx_ready}, {15'd0, m_ready});
      chk("cyc_po", 16'(rx_po), 16'(m_po));
      chk("cyc_error", {15'd0, rx_error}, {15'd0, m_err});
      chk("cyc_overrun", {15'd0, rx_overrun}, {15'd0, m_ovr});
      chk("cyc_parity", {15'd0, rx_parity_err}, {15'd0, m_perr});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] data, input logic par,
                            input logic [1:0] stop, input int leave_low);
    logic ferr;
    logic perr;
    tick();
    ferr = 1'b0;
    for (int i = 0; i < STOP_BITS; i++) begin
      if (!stop[i]) ferr = 1'b1;
    end
    perr = (PAR_BITS != 0) && (((^data) ^ par) != 1'(PARITY_ODD));
    last_done = cyc + 1 + LAT;
    exp_q.push_back('{last_done, data, ferr, perr});
    rx_si = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < DATA_W; i++) begin
      rx_si = data[i];
      repeat (CPB) tick();
    end
    if (PAR_BITS != 0) begin
      rx_si = par;
      repeat (CPB) tick();
    end
    for (int i = 0; i < STOP_BITS; i++) begin
      rx_si = stop[i];
      repeat (CPB) tick();
    end
    if (leave_low == 0) rx_si = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!rx_ready && n < 200) begin
      tick();
      n++;
    end
    chk(name, {15'd0, rx_ready}, 16'd1);
  endtask

  task automatic ack_pulse();
    rx_data_ack = 1'b1;
    tick();
    rx_data_ack = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {15'd0, rx_busy}, 16'd0);
    chk("rst_ready", {15'd0, rx_ready}, 16'd0);
    chk("rst_po", 16'(rx_po), 16'd0);
    chk("rst_error", {15'd0, rx_error}, 16'd0);
    chk("rst_overrun", {15'd0, rx_overrun}, 16'd0);
    chk("rst_parity", {15'd0, rx_parity_err}, 16'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    repeat (4) tick();

`ifdef RX_PARITY_EN
    send_frame(7'h55, 1'b0, 2'b11, 0);
    wait_ready("p_ready_55");
    chk("p_po_55", 16'(rx_po), 16'h0055);
    chk("p_perr_55", {15'd0, rx_parity_err}, 16'd0);
    ack_pulse();

    send_frame(7'h2A, 1'b1, 2'b11, 0);
    wait_ready("p_ready_good");
    chk("p_po_2a", 16'(rx_po), 16'h002A);
    chk("p_perr_good", {15'd0, rx_parity_err}, 16'd0);
    chk("p_err_good", {15'd0, rx_error}, 16'd0);
    ack_pulse();

    send_frame(7'h2A, 1'b0, 2'b11, 0);
    wait_ready("p_ready_bad");
    chk("p_perr_bad", {15'd0, rx_parity_err}, 16'd1);
    ack_pulse();
    chk("p_perr_cleared", {15'd0, rx_parity_err}, 16'd0);

    send_frame(7'h2A, 1'b1, 2'b01, 0);
    wait_ready("p_ready_stop2");
    chk("p_err_stop2", {15'd0, rx_error}, 16'd1);
    chk("p_perr_stop2", {15'd0, rx_parity_err}, 16'd0);
    ack_pulse();
    repeat (6) tick();
`else
    // 0x55, then ack clears ready but keeps the word
    send_frame(8'h55, 1'b0, 2'b11, 0);
    wait_ready("t1_ready");
    chk("t1_po", 16'(rx_po), 16'h0055);
    chk("t1_error", {15'd0, rx_error}, 16'd0);
    ack_pulse();
    chk("t1_ready_after_ack", {15'd0, rx_ready}, 16'd0);
    chk("t1_po_after_ack", 16'(rx_po), 16'h0055);

    // low stop bit, line held low afterwards
    send_frame(8'hD5, 1'b0, 2'b00, 1);
    wait_ready("t2_ready");
    chk("t2_po", 16'(rx_po), 16'h00D5);
    chk("t2_error", {15'd0, rx_error}, 16'd1);
    repeat (CPB) tick();
    chk("t2_busy_held", {15'd0, rx_busy}, 16'd1);
    rx_si = 1'b1;
    begin
      int n;
      n = 0;
      while (rx_busy && n < 10) begin
        tick();
        n++;
      end
    end
    chk("t2_busy_released", {15'd0, rx_busy}, 16'd0);
    ack_pulse();
    chk("t2_error_after_ack", {15'd0, rx_error}, 16'd0);

    // 20 ns start glitch rejected, then a clean frame
    rx_si = 1'b0;
    repeat (2) tick();
    rx_si = 1'b1;
    begin
      int n;
      n = 0;
      while (!rx_busy && n < 6) begin
        tick();
        n++;
      end
    end
    chk("t3_busy_rise", {15'd0, rx_busy}, 16'd1);
    begin
      int n;
      n = 0;
      while (rx_busy && n < CPB + 4) begin
        tick();
        n++;
      end
    end
    chk("t3_busy_clear", {15'd0, rx_busy}, 16'd0);
    repeat (4) tick();
    chk("t3_no_ready", {15'd0, rx_ready}, 16'd0);
    send_frame(8'h3C, 1'b0, 2'b11, 0);
    wait_ready("t3_ready");
    chk("t3_po", 16'(rx_po), 16'h003C);
    ack_pulse();

    // overrun, then ack landing on the completing edge
    send_frame(8'h55, 1'b0, 2'b11, 0);
    send_frame(8'hA3, 1'b0, 2'b11, 0);
    repeat (2) tick();
    chk("t4_po_kept", 16'(rx_po), 16'h0055);
    chk("t4_overrun", {15'd0, rx_overrun}, 16'd1);
    chk("t4_ready", {15'd0, rx_ready}, 16'd1);
    ack_pulse();
    chk("t4_ready_cleared", {15'd0, rx_ready}, 16'd0);
    chk("t4_overrun_cleared", {15'd0, rx_overrun}, 16'd0);
    chk("t4_error_cleared", {15'd0, rx_error}, 16'd0);
    send_frame(8'h55, 1'b0, 2'b11, 0);
    wait_ready("t4_ready_again");
    fork
      send_frame(8'hA3, 1'b0, 2'b11, 0);
      begin
        @(posedge clk);
        #2;
        while (cyc < last_done - 1) begin
          @(posedge clk);
          #2;
        end
        rx_data_ack = 1'b1;
        @(posedge clk);
        #2;
        rx_data_ack = 1'b0;
      end
    join
    chk("t4_po_same_cycle", 16'(rx_po), 16'h00A3);
    chk("t4_overrun_same_cycle", {15'd0, rx_overrun}, 16'd0);
    chk("t4_ready_same_cycle", {15'd0, rx_ready}, 16'd1);
    ack_pulse();

    // asynchronous reset mid-data
    tick();
    rx_si = 1'b0;
    repeat (CPB) tick();
    rx_si = 1'b1;
    repeat (CPB) tick();
    rx_si = 1'b0;
    repeat (CPB / 2) tick();
    chk("t6_busy_before", {15'd0, rx_busy}, 16'd1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    rx_si = 1'b1;
    #1;
    chk("t6_busy_async", {15'd0, rx_busy}, 16'd0);
    chk("t6_ready_async", {15'd0, rx_ready}, 16'd0);
    chk("t6_po_async", 16'(rx_po), 16'd0);
    #2;
    rst = 1'b0;
    repeat (4) tick();
    send_frame(8'h81, 1'b0, 2'b11, 0);
    wait_ready("t6_ready");
    chk("t6_po", 16'(rx_po), 16'h0081);
    chk("t6_error", {15'd0, rx_error}, 16'd0);
    ack_pulse();
    repeat (6) tick();
`endif

    chk("end_queue_empty", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog run did not complete at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
